// File: rtl/ads1115_target_pkg.sv
// ads1115_target_pkg: register map, reset values and FSM states of the ADS1115 target
package ads1115_target_pkg;
  localparam logic [1:0] REG_CONV = 2'd0, REG_CONFIG = 2'd1, REG_LO = 2'd2, REG_HI = 2'd3;
  localparam logic [15:0] CONFIG_RST = 16'h8583, LO_RST = 16'h8000, HI_RST = 16'h7FFF;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WR_MSB, S_WR_MSB_ACK,
    S_WR_LSB, S_WR_LSB_ACK, S_RD_MSB, S_RD_MSB_ACK, S_RD_LSB, S_RD_LSB_ACK, S_IGNORE
  } state_t;
endpackage

// File: rtl/ads1115_target_i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [2:0] scl_q, sda_q;
  logic sda_rise, sda_fall;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], i_scl};
      sda_q <= {sda_q[1:0], i_sda};
    end
  assign sda = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign sda_rise = sda_q[1] & ~sda_q[2];
  assign sda_fall = ~sda_q[1] & sda_q[2];
  assign start = sda_fall & scl_q[1];
  assign stop = sda_rise & scl_q[1];
endmodule

// File: rtl/ads1115_target.sv
// ads1115_target: I2C target serving the ADS1115 register map from fabric logic
module ads1115_target #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter logic [6:0]  ADDR       = 7'h48,
  parameter logic [15:0] CONFIG_RST = ads1115_target_pkg::CONFIG_RST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda,
  input  logic [15:0] i_conv_data,
  input  logic        i_conv_valid,
  output logic [15:0] o_config,
  output logic [15:0] o_lo_thresh,
  output logic [15:0] o_hi_thresh,
  output logic        o_start,
  output logic        o_busy
);
  import ads1115_target_pkg::*;
  if (CLK_FREQ == 0) begin : g_bad_clk
    $error("CLK_FREQ must be nonzero");
  end
  state_t state, state_n, ack_next;
  logic [2:0] cnt, cnt_n;
  logic [15:0] sh, sh_n, conv, snap, word;
  logic [7:0] hold, hold_n, rx_byte;
  logic [1:0] ptr, ptr_n;
  logic rw, rw_n, sda_n, wr_en, sda, scl_rise, scl_fall, start, stop;
  i2c_bus_monitor u_mon (
    .clk(clk), .rst(rst), .i_scl(i_scl), .i_sda(i_sda), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign rx_byte = {sh[6:0], sda};
  assign word = {hold, rx_byte};
  // a conversion landing on the snapshot cycle is captured, never lost
  assign snap = ptr == REG_CONV ? (i_conv_valid ? i_conv_data : conv) :
                ptr == REG_CONFIG ? o_config : ptr == REG_LO ? o_lo_thresh : o_hi_thresh;
  assign ack_next = state == S_ADDR_ACK ? (rw ? S_RD_MSB : S_PTR) :
                    state == S_PTR_ACK ? S_WR_MSB : state == S_WR_MSB_ACK ? S_WR_LSB : S_WR_MSB;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    hold_n = hold;
    ptr_n = ptr;
    rw_n = rw;
    sda_n = o_sda;
    wr_en = 1'b0;
    if (start || stop) begin
      state_n = start ? S_ADDR : S_IDLE;
      cnt_n = '0;
      sda_n = 1'b1;
    end else case (state)
      S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB: if (scl_rise) begin
        sh_n = {sh[14:0], sda};
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd7) begin
          rw_n = state == S_ADDR ? rx_byte[0] : rw;
          ptr_n = state == S_PTR ? rx_byte[1:0] : ptr;
          hold_n = state == S_WR_MSB ? rx_byte : hold;
          wr_en = state == S_WR_LSB;
          state_n = state == S_ADDR ? (rx_byte[7:1] == ADDR ? S_ADDR_ACK : S_IGNORE) :
                    state == S_PTR ? S_PTR_ACK : state == S_WR_MSB ? S_WR_MSB_ACK : S_WR_LSB_ACK;
        end
      end
      // o_sda doubles as the ACK phase: first fall pulls low, second releases
      S_ADDR_ACK, S_PTR_ACK, S_WR_MSB_ACK, S_WR_LSB_ACK: if (scl_fall) begin
        sda_n = ~o_sda;
        if (!o_sda) begin
          state_n = ack_next;
          if (ack_next == S_RD_MSB) begin
            sh_n = snap;
            sda_n = snap[15];
          end
        end
      end
      S_RD_MSB, S_RD_LSB: if (scl_fall) begin
        sh_n = {sh[14:0], 1'b0};
        cnt_n = cnt + 3'd1;
        sda_n = cnt == 3'd7 ? 1'b1 : sh[14];
        if (cnt == 3'd7) state_n = state == S_RD_MSB ? S_RD_MSB_ACK : S_RD_LSB_ACK;
      end
      S_RD_MSB_ACK, S_RD_LSB_ACK: begin
        if (scl_rise && sda) state_n = S_IGNORE;
        else if (scl_fall) begin
          state_n = state == S_RD_MSB_ACK ? S_RD_LSB : S_RD_MSB;
          sh_n = state == S_RD_MSB_ACK ? sh : snap;
          sda_n = sh_n[15];
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      sh <= '0;
      hold <= '0;
      ptr <= REG_CONV;
      rw <= 1'b0;
      o_sda <= 1'b1;
      o_busy <= 1'b0;
      o_start <= 1'b0;
      conv <= '0;
      o_config <= CONFIG_RST;
      o_lo_thresh <= LO_RST;
      o_hi_thresh <= HI_RST;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      hold <= hold_n;
      ptr <= ptr_n;
      rw <= rw_n;
      o_sda <= sda_n;
      o_busy <= start | (o_busy & ~stop);
      o_start <= wr_en && ptr == REG_CONFIG && word[15];
      if (i_conv_valid) conv <= i_conv_data;
      if (wr_en && ptr == REG_CONFIG) o_config <= {1'b0, word[14:0]};
      if (wr_en && ptr == REG_LO) o_lo_thresh <= word;
      if (wr_en && ptr == REG_HI) o_hi_thresh <= word;
    end
endmodule

// File: tb/tb_ads1115_target.sv
// tb_ads1115_target: bit-banged I2C master checking the ADS1115 target against a register model
module tb_ads1115_target;
  localparam int Q = 6;
  typedef struct {
    logic [7:0]  pb;
    logic [15:0] data;
    logic [15:0] rb;
    int          st;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1, conv_valid = 1'b0;
  logic [15:0] conv_data = '0;
  logic o_sda, o_start, o_busy;
  logic [15:0] o_config, o_lo_thresh, o_hi_thresh;
  wire sda_bus = m_sda & o_sda;
  int n_checks = 0, n_fail = 0, start_cycles = 0, low_cycles = 0;
  bit watch_low = 1'b0;
  vec_t tbl[6];
  logic [15:0] mdl[4];
  logic [15:0] q[3];
  always #5 clk = ~clk;
  ads1115_target dut (
    .clk(clk), .rst(rst), .i_scl(m_scl), .i_sda(sda_bus), .o_sda(o_sda),
    .i_conv_data(conv_data), .i_conv_valid(conv_valid), .o_config(o_config),
    .o_lo_thresh(o_lo_thresh), .o_hi_thresh(o_hi_thresh), .o_start(o_start), .o_busy(o_busy)
  );
  always @(posedge clk) begin
    if (o_start) start_cycles <= start_cycles + 1;
    if (watch_low && !o_sda) low_cycles <= low_cycles + 1;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic w(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; w(Q); m_scl = 1'b1; w(Q); m_sda = 1'b0; w(Q); m_scl = 1'b0; w(Q);
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; w(Q); m_scl = 1'b1; w(Q); m_sda = 1'b1; w(Q);
  endtask
  task automatic put_bit(input logic b);
    m_sda = b; w(Q); m_scl = 1'b1; w(2 * Q); m_scl = 1'b0; w(Q);
  endtask
  task automatic get_bit(output logic b);
    m_sda = 1'b1; w(Q); m_scl = 1'b1; w(Q); b = sda_bus; w(Q); m_scl = 1'b0; w(Q);
  endtask
  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic [7:0] s;
    logic b;
    s = d;
    for (int i = 0; i < 8; i++) begin
      put_bit(s[7]);
      s = s << 1;
    end
    get_bit(b);
    ack = ~b;
  endtask
  task automatic get_byte(input logic ack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    put_bit(~ack);
  endtask
  task automatic wr(input logic [7:0] ab, input logic [7:0] pb, input int n,
                    input logic [15:0] d0, input logic [15:0] d1, output int acks);
    logic a;
    acks = 0;
    i2c_start;
    put_byte(ab, a); acks += int'(a);
    put_byte(pb, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      put_byte(i == 0 ? d0[15:8] : d1[15:8], a); acks += int'(a);
      put_byte(i == 0 ? d0[7:0] : d1[7:0], a); acks += int'(a);
    end
    i2c_stop;
  endtask
  task automatic rd(input logic [7:0] pb, input int n, output logic [15:0] r[3], output int acks);
    logic a;
    logic [7:0] hb, lb;
    acks = 0;
    r = '{default: '0};
    i2c_start;
    put_byte(8'h90, a); acks += int'(a);
    put_byte(pb, a); acks += int'(a);
    i2c_start;
    put_byte(8'h91, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      get_byte(1'b1, hb);
      get_byte(i < n - 1, lb);
      r[i] = {hb, lb};
    end
    i2c_stop;
  endtask
  task automatic conv(input logic [15:0] v);
    conv_data = v; conv_valid = 1'b1; w(1); conv_valid = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int acks, s0, exp_st, kind, n;
    logic a;
    logic [7:0] hb, lb, part;
    logic [1:0] p;
    logic [6:0] wa;
    logic [15:0] d0, d1;
    w(4);
    rst = 1'b0;
    w(4);
    check("rst_sda", o_sda, 1);
    check("rst_start", o_start, 0);
    check("rst_busy", o_busy, 0);
    check("rst_config", o_config, 16'h8583);
    check("rst_lo", o_lo_thresh, 16'h8000);
    check("rst_hi", o_hi_thresh, 16'h7FFF);
    s0 = start_cycles;
    acks = 0;
    i2c_start;
    check("busy_after_start", o_busy, 1);
    put_byte(8'h90, a); acks += int'(a);
    put_byte(8'h01, a); acks += int'(a);
    put_byte(8'h84, a); acks += int'(a);
    put_byte(8'h83, a); acks += int'(a);
    i2c_stop;
    check("cfg_acks", acks, 4);
    check("cfg_value", o_config, 16'h0483);
    check("cfg_start_pulse", start_cycles - s0, 1);
    check("busy_after_stop", o_busy, 0);
    conv(16'h1234);
    rd(8'h00, 1, q, acks);
    check("conv_acks", acks, 3);
    check("conv_read", q[0], 16'h1234);
    check("conv_sda_released", o_sda, 1);
    low_cycles = 0;
    watch_low = 1'b1;
    wr(8'h92, 8'h01, 1, 16'h1234, 16'h0, acks);
    watch_low = 1'b0;
    check("wrong_addr_acks", acks, 0);
    check("wrong_addr_sda_low", low_cycles, 0);
    check("wrong_addr_config", o_config, 16'h0483);
    i2c_start;
    put_byte(8'h90, a); put_byte(8'h00, a);
    i2c_start;
    put_byte(8'h91, a);
    get_byte(1'b1, hb);
    conv(16'hABCD);
    get_byte(1'b0, lb);
    i2c_stop;
    check("coherent_msb", hb, 8'h12);
    check("coherent_lsb", lb, 8'h34);
    rd(8'h00, 1, q, acks);
    check("coherent_next", q[0], 16'hABCD);
    i2c_start;
    put_byte(8'h90, a); put_byte(8'h03, a); put_byte(8'h12, a);
    part = 8'h34;
    for (int i = 0; i < 4; i++) begin
      put_bit(part[7]);
      part = part << 1;
    end
    i2c_stop;
    check("abort_hi", o_hi_thresh, 16'h7FFF);
    check("abort_idle", o_busy, 0);
    wr(8'h90, 8'h03, 1, 16'h1000, 16'h0, acks);
    check("abort_retry_acks", acks, 4);
    check("abort_retry_hi", o_hi_thresh, 16'h1000);
    conv(16'h1234);
    i2c_start;
    put_byte(8'h90, a); put_byte(8'h00, a);
    i2c_start;
    put_byte(8'h91, a);
    n = 0;
    while (o_sda !== 1'b0 && n < 50) begin
      w(1);
      n++;
    end
    check("rst_mid_drive_low", o_sda, 0);
    #2 rst = 1'b1;
    #1 check("rst_mid_sda_release", o_sda, 1);
    check("rst_mid_config", o_config, 16'h8583);
    check("rst_mid_hi", o_hi_thresh, 16'h7FFF);
    check("rst_mid_busy", o_busy, 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    w(3);
    rst = 1'b0;
    w(3);
    rd(8'h00, 1, q, acks);
    check("rst_mid_conv", q[0], 16'h0000);
    tbl[0] = '{8'h01, 16'h0483, 16'h0483, 0};
    tbl[1] = '{8'h01, 16'hC3E3, 16'h43E3, 1};
    tbl[2] = '{8'hFE, 16'h1234, 16'h1234, 0};
    tbl[3] = '{8'h03, 16'hFFFF, 16'hFFFF, 0};
    tbl[4] = '{8'h00, 16'h5555, 16'h0000, 0};
    tbl[5] = '{8'hFD, 16'h7FFF, 16'h7FFF, 0};
    foreach (tbl[i]) begin
      s0 = start_cycles;
      wr(8'h90, tbl[i].pb, 1, tbl[i].data, 16'h0, acks);
      check($sformatf("tbl%0d_acks", i), acks, 4);
      check($sformatf("tbl%0d_start", i), start_cycles - s0, tbl[i].st);
      rd(tbl[i].pb, 1, q, acks);
      check($sformatf("tbl%0d_read", i), q[0], tbl[i].rb);
    end
    rst = 1'b1;
    w(2);
    rst = 1'b0;
    w(2);
    mdl = '{16'h0000, 16'h8583, 16'h8000, 16'h7FFF};
    for (int t = 0; t < 25; t++) begin
      kind = int'($urandom_range(0, 9));
      p = 2'($urandom_range(0, 3));
      if (kind < 2) begin
        d0 = 16'($urandom);
        conv(d0);
        mdl[0] = d0;
      end
      if (kind < 5) begin
        n = int'($urandom_range(1, 2));
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        s0 = start_cycles;
        wr(8'h90, {6'($urandom), p}, n, d0, d1, acks);
        exp_st = 0;
        for (int k = 0; k < n; k++) begin
          if (p == 2'd1) begin
            mdl[1] = (k == 0 ? d0 : d1) & 16'h7FFF;
            exp_st += int'((k == 0 ? d0[15] : d1[15]));
          end else if (p != 2'd0) mdl[p] = k == 0 ? d0 : d1;
        end
        check($sformatf("rnd%0d_wr_acks", t), acks, 2 + 2 * n);
        check($sformatf("rnd%0d_start", t), start_cycles - s0, exp_st);
      end else if (kind < 9) begin
        n = int'($urandom_range(1, 3));
        rd({6'($urandom), p}, n, q, acks);
        check($sformatf("rnd%0d_rd_acks", t), acks, 3);
        for (int k = 0; k < n; k++) check($sformatf("rnd%0d_rd%0d", t, k), q[k], mdl[p]);
      end else begin
        wa = 7'($urandom);
        if (wa == 7'h48) wa = 7'h49;
        wr({wa, 1'b0}, {6'b0, p}, 1, 16'($urandom), 16'h0, acks);
        check($sformatf("rnd%0d_nack", t), acks, 0);
      end
      check($sformatf("rnd%0d_config", t), o_config, mdl[1]);
      check($sformatf("rnd%0d_lo", t), o_lo_thresh, mdl[2]);
      check($sformatf("rnd%0d_hi", t), o_hi_thresh, mdl[3]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
